// File: rtl/mem_requester.sv
// mem_requester: single-outstanding initiator for the cache memory system's
// Rd/Wr/Done handshake. Holds Addr/DataIn/Rd/Wr stable until Done or timeout,
// returns a registered one-cycle response and keeps saturating access/hit counts.
module mem_requester #(
    parameter int TIMEOUT     = 64,
    parameter int CHECK_ALIGN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [15:0]      resp_rdata,
    output logic             resp_err,
    output logic             resp_hit,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_hit,
    input  logic             mem_err,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    // Wait counter only needs to reach TIMEOUT-1 (the last REQ cycle allowed).
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              resp_valid_q, resp_valid_d;
    logic [15:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_hit_q, resp_hit_d;
    logic [CNT_W-1:0]  access_q, access_d;
    logic [CNT_W-1:0]  hits_q, hits_d;

    // Stall is informational; the handshake is governed by Done alone.
    logic unused_stall;
    assign unused_stall = mem_stall;

    // State and datapath registers; async active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            access_q     <= '0;
            hits_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_hit_q   <= resp_hit_d;
            access_q     <= access_d;
            hits_q       <= hits_d;
        end
    end

    // Next-state, handshake outputs and response capture.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_d       = wait_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        resp_hit_d   = resp_hit_q;
        access_d     = access_q;
        hits_d       = hits_q;
        req_ready    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wait_d  = '0;
                    if ((CHECK_ALIGN != 0) && req_addr[0]) begin
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                mem_rd = ~wr_q;
                mem_wr = wr_q;
                wait_d = wait_q + 1'b1;
                // Done is checked first so it wins over a coincident timeout.
                if (mem_done) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wr_q ? 16'h0000 : mem_rdata;
                    resp_hit_d   = mem_hit;
                    resp_err_d   = mem_err;
                    if (access_q != {CNT_W{1'b1}}) access_d = access_q + 1'b1;
                    if (mem_hit && (hits_q != {CNT_W{1'b1}})) hits_d = hits_q + 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 16'h0000;
                    resp_hit_d   = 1'b0;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            ERR: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 16'h0000;
                resp_hit_d   = 1'b0;
                resp_err_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign resp_hit   = resp_hit_q;
    assign access_cnt = access_q;
    assign hit_cnt    = hits_q;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_mem_requester;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_wr;
    logic [15:0]      req_addr, req_wdata;
    logic             req_ready, resp_valid, resp_err, resp_hit;
    logic [15:0]      resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic             mem_rd, mem_wr, mem_done, mem_stall, mem_hit, mem_err;
    logic [CNT_W-1:0] access_cnt, hit_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_acc = 0;
    int exp_hit = 0;
    logic [15:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        last_hit = 1'b0;

    mem_requester #(.TIMEOUT(TIMEOUT), .CHECK_ALIGN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_hit(resp_hit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_hit(mem_hit), .mem_err(mem_err),
        .access_cnt(access_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response expected in the current cycle; also records held values.
    task automatic check_resp(input string tag, input logic [15:0] rdata, input logic err, input logic hit);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_rdata"}, 32'(resp_rdata), 32'(rdata));
        check({tag, "_err"},   32'(resp_err),   32'(err));
        check({tag, "_hit"},   32'(resp_hit),   32'(hit));
        check({tag, "_acc"},   32'(access_cnt), 32'(exp_acc));
        check({tag, "_hcnt"},  32'(hit_cnt),    32'(exp_hit));
        check({tag, "_ready"}, 32'(req_ready),  32'd1);
        last_rdata = rdata;
        last_err   = err;
        last_hit   = hit;
        $display("txn %s: rdata=%h err=%0d hit=%0d acc=%0d hits=%0d",
                 tag, resp_rdata, resp_err, resp_hit, access_cnt, hit_cnt);
    endtask

    // One request; delay = REQ-cycle index at which Done is driven (>=TIMEOUT means never).
    task automatic txn(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata,
                       input logic hit, input logic err, input int delay);
        check({tag, "_accept"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        if (addr[0]) begin
            check({tag, "_nomem"}, 32'({mem_rd, mem_wr}), 32'd0);
            check({tag, "_busy"},  32'({req_ready, resp_valid}), 32'd0);
            tick();
            check({tag, "_nomem2"}, 32'({mem_rd, mem_wr}), 32'd0);
            check_resp(tag, 16'h0000, 1'b1, 1'b0);
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                check({tag, "_rdwr"}, 32'({mem_rd, mem_wr}), 32'({~wr, wr}));
                check({tag, "_addr"}, {mem_addr, mem_wdata}, {addr, wdata});
                check({tag, "_busy"}, 32'({req_ready, resp_valid}), 32'd0);
                if (k == delay) begin
                    mem_done  = 1'b1;
                    mem_rdata = rdata;
                    mem_hit   = hit;
                    mem_err   = err;
                end else begin
                    mem_done  = 1'b0;
                    mem_rdata = 16'($urandom);
                    mem_hit   = 1'($urandom);
                    mem_err   = 1'($urandom);
                end
                tick();
                mem_done = 1'b0;
                if (k == delay) break;
            end
            if (delay < TIMEOUT) begin
                if (exp_acc < CMAX) exp_acc++;
                if (hit && exp_hit < CMAX) exp_hit++;
                check_resp(tag, wr ? 16'h0000 : rdata, err, hit);
            end else begin
                check({tag, "_tmo_drop"}, 32'({mem_rd, mem_wr}), 32'd0);
                check_resp(tag, 16'h0000, 1'b1, 1'b0);
            end
        end
    endtask

    // Idle cycles with stray Done pulses that must be ignored.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            mem_done = 1'($urandom);
            mem_hit  = 1'b1;
            mem_err  = 1'($urandom);
            tick();
            mem_done = 1'b0;
            check({tag, "_novalid"}, 32'(resp_valid), 32'd0);
            check({tag, "_hold"}, 32'({resp_rdata, resp_err, resp_hit}),
                  32'({last_rdata, last_err, last_hit}));
            check({tag, "_cnt"}, 32'({access_cnt, hit_cnt}), 32'({exp_acc[CNT_W-1:0], exp_hit[CNT_W-1:0]}));
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0; mem_err = 1'b0;
        #1;
        check("rst_resp", 32'({resp_valid, resp_err, resp_hit}), 32'd0);
        check("rst_rdata", 32'(resp_rdata), 32'd0);
        check("rst_mem", 32'({mem_rd, mem_wr}), 32'd0);
        check("rst_addr", {mem_addr, mem_wdata}, 32'd0);
        check("rst_cnt", 32'({access_cnt, hit_cnt}), 32'd0);
        tick(); tick();
        rst = 1'b1;
        idle("boot", 2);

        txn("t1_load",  1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1);
        idle("t1", 1);
        txn("t2_store", 1'b1, 16'h0222, 16'h1234, 16'hAAAA, 1'b0, 1'b0, 20);
        idle("t2", 1);
        txn("t3_misal", 1'b0, 16'h0003, 16'h0000, 16'h5555, 1'b1, 1'b0, 0);
        idle("t3", 1);
        txn("t4_tmo",   1'b0, 16'h0400, 16'h0000, 16'h7777, 1'b1, 1'b0, 1000);
        txn("t4_next",  1'b0, 16'h0402, 16'h0000, 16'h1111, 1'b0, 1'b0, 0);
        txn("t5_err",   1'b0, 16'h0600, 16'h0000, 16'hCAFE, 1'b1, 1'b1, 2);
        txn("t5_b2b",   1'b1, 16'h0602, 16'h9999, 16'h2222, 1'b1, 1'b0, 0);
        txn("edge_last", 1'b0, 16'h0800, 16'h0000, 16'h4321, 1'b0, 1'b0, TIMEOUT - 1);
        idle("t5", 2);

        for (int i = 0; i < 40; i++) begin
            logic        wr, hit, err;
            logic [15:0] addr, wdata, rdata;
            int          delay, sel;
            wr    = 1'($urandom);
            hit   = 1'($urandom);
            err   = ($urandom_range(0, 5) == 0);
            addr  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) addr[0] = 1'b1;
            wdata = 16'($urandom);
            rdata = 16'($urandom);
            sel   = $urandom_range(0, 19);
            delay = (sel == 0) ? TIMEOUT : (sel == 1) ? TIMEOUT - 1 : $urandom_range(0, 6);
            txn("rnd", wr, addr, wdata, rdata, hit, err, delay);
            idle("rnd", $urandom_range(0, 2));
        end

        // Reset during an outstanding load.
        check("t6_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0A00;
        tick();
        req_valid = 1'b0;
        check("t6_rd_before", 32'(mem_rd), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rd_drop", 32'({mem_rd, mem_wr}), 32'd0);
        check("t6_cnt_clr", 32'({access_cnt, hit_cnt}), 32'd0);
        exp_acc = 0; exp_hit = 0;
        last_rdata = '0; last_err = 1'b0; last_hit = 1'b0;
        tick(); tick();
        rst = 1'b1;
        idle("t6_after", 5);
        check("t6_nomem", 32'({mem_rd, mem_wr}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
